// File: rtl/turn_pkg.sv
// rtl/turn_pkg.sv - shared state type, key constant and sizing helper for the turn arbiter
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        FLIGHT,
        SETTLE,
        NEXT,
        GAMEOVER
    } turn_state_t;

    localparam logic [7:0] DEFAULT_FIRE_KEY = 8'h2C;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_next_alive.sv
// rtl/rr_next_alive.sv - round-robin search for the next alive index after the current one
module rr_next_alive #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [ID_W-1:0] cur,
    input  logic [N-1:0]    alive,
    output logic [ID_W-1:0] next_idx,
    output logic            valid
);

    // Scan far-to-near so the nearest alive index after cur wins; cur itself is never chosen
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        for (int i = N - 1; i >= 1; i--) begin
            if (alive[(int'(cur) + i) % N]) begin
                next_idx = ID_W'((int'(cur) + i) % N);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_arbiter.sv
// rtl/turn_arbiter.sv - N-player turn sequencer with key routing, terrain gating and draw mux
module turn_arbiter
    import turn_pkg::*;
#(
    parameter int         N_PLAYERS     = 2,
    parameter int         TURN_FRAMES   = 600,
    parameter int         SETTLE_FRAMES = 30,
    parameter int         ADDR_W        = 11,
    parameter logic [7:0] FIRE_KEY      = DEFAULT_FIRE_KEY,
    localparam int        ID_W          = $clog2(N_PLAYERS),
    localparam int        TL_W          = $clog2(TURN_FRAMES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_clk,
    input  logic [7:0]                  keycode,
    input  logic                        blank,
    input  logic [N_PLAYERS-1:0]        alive,
    input  logic [N_PLAYERS-1:0]        bomb_done,
    input  logic [N_PLAYERS-1:0]        draw_player,
    input  logic [N_PLAYERS-1:0]        draw_bomb,
    input  logic [N_PLAYERS*ADDR_W-1:0] addr_player,
    input  logic [N_PLAYERS*ADDR_W-1:0] addr_bomb,
    output logic [N_PLAYERS*8-1:0]      key_out,
    output logic [ID_W-1:0]             active_id,
    output logic [TL_W-1:0]             turn_left,
    output logic                        terrain_we,
    output logic                        draw_player_o,
    output logic                        draw_bomb_o,
    output logic [ADDR_W-1:0]           addr_player_o,
    output logic [ADDR_W-1:0]           addr_bomb_o,
    output logic                        game_over,
    output logic [ID_W-1:0]             winner
);

    // One counter serves both the AIM timeout and the SETTLE hold, so it must fit the larger
    localparam int CNT_W = $clog2(max_int(TURN_FRAMES, SETTLE_FRAMES) + 1);

    turn_state_t            state, state_n;
    logic [CNT_W-1:0]       frame_cnt, cnt_n;
    logic [ID_W-1:0]        active_n, winner_n, rr_idx, low_alive;
    logic [N_PLAYERS*8-1:0] key_n;
    logic                   over_n, rr_valid, frame_clk_q, tick;

    assign tick = frame_clk & ~frame_clk_q;

    rr_next_alive #(
        .N    (N_PLAYERS),
        .ID_W (ID_W)
    ) u_rr (
        .cur      (active_id),
        .alive    (alive),
        .next_idx (rr_idx),
        .valid    (rr_valid)
    );

    // Lowest alive index names the winner; 0 when nobody is left
    always_comb begin
        low_alive = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (alive[i]) low_alive = ID_W'(i);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame_clk_q <= 1'b0;
            frame_cnt   <= CNT_W'(TURN_FRAMES);
            active_id   <= '0;
            key_out     <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
        end else begin
            state       <= state_n;
            frame_clk_q <= frame_clk;
            frame_cnt   <= cnt_n;
            active_id   <= active_n;
            key_out     <= key_n;
            game_over   <= over_n;
            winner      <= winner_n;
        end
    end

    // Turn sequencing: next state, counter, key routing and end-of-game bookkeeping
    always_comb begin
        state_n  = state;
        cnt_n    = frame_cnt;
        active_n = active_id;
        key_n    = '0;
        over_n   = game_over;
        winner_n = winner;
        case (state)
            IDLE: begin
                if (tick) state_n = AIM;
            end
            AIM: begin
                key_n[int'(active_id)*8 +: 8] = keycode;
                if (tick && frame_cnt != '0) cnt_n = frame_cnt - CNT_W'(1);
                if (!alive[active_id])       state_n = NEXT;
                else if (keycode == FIRE_KEY) state_n = FLIGHT;
                else if (frame_cnt == '0)     state_n = NEXT;
            end
            FLIGHT: begin
                if (bomb_done[active_id]) begin
                    state_n = SETTLE;
                    cnt_n   = CNT_W'(SETTLE_FRAMES);
                end
            end
            SETTLE: begin
                if (frame_cnt == '0) state_n = NEXT;
                else if (tick)       cnt_n = frame_cnt - CNT_W'(1);
            end
            NEXT: begin
                cnt_n = CNT_W'(TURN_FRAMES);
                if ($countones(alive) <= 1 || !rr_valid) begin
                    state_n  = GAMEOVER;
                    over_n   = 1'b1;
                    winner_n = low_alive;
                end else begin
                    state_n  = AIM;
                    active_n = rr_idx;
                end
            end
            GAMEOVER: begin
                over_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // The shared counter holds the crater hold time in SETTLE; the HEX display shows no aim time then
    assign turn_left = (state == SETTLE) ? '0 : frame_cnt[TL_W-1:0];

    // Terrain writes only while a bomb is live or settling, and never under the active bomb sprite
    assign terrain_we = blank & ~draw_bomb[active_id] & ((state == FLIGHT) | (state == SETTLE));

    assign draw_player_o = |draw_player;
    assign draw_bomb_o   = |draw_bomb;

    // Zero-latency draw address mux, lowest asserting index wins
    always_comb begin
        addr_player_o = '0;
        addr_bomb_o   = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (draw_player[i]) addr_player_o = addr_player[i*ADDR_W +: ADDR_W];
            if (draw_bomb[i])   addr_bomb_o   = addr_bomb[i*ADDR_W +: ADDR_W];
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// tb/tb_turn_arbiter.sv - directed self-checking bench for turn_arbiter
module tb_turn_arbiter;

    logic        clk = 1'b0;
    logic        reset, frame_clk, blank;
    logic [7:0]  keycode;

    logic [1:0]  alive_a, bomb_done_a, draw_player_a, draw_bomb_a;
    logic [21:0] addr_player_a, addr_bomb_a;
    logic [15:0] key_out_a;
    logic        active_id_a, winner_a, game_over_a;
    logic [9:0]  turn_left_a;
    logic        terrain_we_a, draw_player_o_a, draw_bomb_o_a;
    logic [10:0] addr_player_o_a, addr_bomb_o_a;

    logic [3:0]  alive_b, bomb_done_b, draw_player_b, draw_bomb_b;
    logic [43:0] addr_player_b, addr_bomb_b;
    logic [31:0] key_out_b;
    logic [1:0]  active_id_b, winner_b;
    logic        game_over_b;
    logic [2:0]  turn_left_b;
    logic        terrain_we_b, draw_player_o_b, draw_bomb_o_b;
    logic [10:0] addr_player_o_b, addr_bomb_o_b;

    int n_cmp = 0;
    int n_err = 0;

    turn_arbiter #(.N_PLAYERS(2)) u_a (
        .clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode), .blank(blank),
        .alive(alive_a), .bomb_done(bomb_done_a), .draw_player(draw_player_a), .draw_bomb(draw_bomb_a),
        .addr_player(addr_player_a), .addr_bomb(addr_bomb_a), .key_out(key_out_a),
        .active_id(active_id_a), .turn_left(turn_left_a), .terrain_we(terrain_we_a),
        .draw_player_o(draw_player_o_a), .draw_bomb_o(draw_bomb_o_a),
        .addr_player_o(addr_player_o_a), .addr_bomb_o(addr_bomb_o_a),
        .game_over(game_over_a), .winner(winner_a)
    );

    turn_arbiter #(.N_PLAYERS(4), .TURN_FRAMES(5), .SETTLE_FRAMES(3)) u_b (
        .clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode), .blank(blank),
        .alive(alive_b), .bomb_done(bomb_done_b), .draw_player(draw_player_b), .draw_bomb(draw_bomb_b),
        .addr_player(addr_player_b), .addr_bomb(addr_bomb_b), .key_out(key_out_b),
        .active_id(active_id_b), .turn_left(turn_left_b), .terrain_we(terrain_we_b),
        .draw_player_o(draw_player_o_b), .draw_bomb_o(draw_bomb_o_b),
        .addr_player_o(addr_player_o_b), .addr_bomb_o(addr_bomb_o_b),
        .game_over(game_over_b), .winner(winner_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        frame_clk = 0; blank = 0; keycode = 8'h00;
        alive_a = 2'b11; bomb_done_a = '0; draw_player_a = '0; draw_bomb_a = '0;
        addr_player_a = '0; addr_bomb_a = '0;
        alive_b = 4'b0011; bomb_done_b = '0; draw_player_b = '0; draw_bomb_b = '0;
        addr_player_b = '0; addr_bomb_b = '0;
        do_reset();
        n_cmp++; if (key_out_a !== 16'h0) begin n_err++; $display("FAIL reset_key_out: got %0h expected 0", key_out_a); end
        n_cmp++; if (active_id_a !== 1'b0) begin n_err++; $display("FAIL reset_active_id: got %0d expected 0", active_id_a); end
        n_cmp++; if (turn_left_a !== 10'd600) begin n_err++; $display("FAIL reset_turn_left: got %0d expected 600", turn_left_a); end
        n_cmp++; if (game_over_a !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %0d expected 0", game_over_a); end
        n_cmp++; if (winner_a !== 1'b0) begin n_err++; $display("FAIL reset_winner: got %0d expected 0", winner_a); end
        n_cmp++; if (turn_left_b !== 3'd5) begin n_err++; $display("FAIL reset_turn_left_b: got %0d expected 5", turn_left_b); end
        blank = 1'b1;
        #1;
        n_cmp++; if (terrain_we_a !== 1'b0) begin n_err++; $display("FAIL idle_terrain_we: got %0d expected 0", terrain_we_a); end
    endtask

    task automatic test_turn_start();
        tick();
        n_cmp++; if (turn_left_a !== 10'd600) begin n_err++; $display("FAIL start_turn_left: got %0d expected 600", turn_left_a); end
        n_cmp++; if (active_id_a !== 1'b0) begin n_err++; $display("FAIL start_active_id: got %0d expected 0", active_id_a); end
        n_cmp++; if (terrain_we_a !== 1'b0) begin n_err++; $display("FAIL aim_terrain_we: got %0d expected 0", terrain_we_a); end
    endtask

    task automatic test_key_route();
        keycode = 8'h04;
        cyc();
        n_cmp++; if (key_out_a !== 16'h0004) begin n_err++; $display("FAIL route_key_a: got %0h expected 0004", key_out_a); end
        n_cmp++; if (key_out_b !== 32'h4) begin n_err++; $display("FAIL route_key_b: got %0h expected 4", key_out_b); end
        keycode = 8'h2C;
        cyc();
        n_cmp++; if (key_out_a !== 16'h002C) begin n_err++; $display("FAIL fire_key_routed: got %0h expected 002c", key_out_a); end
        keycode = 8'h00;
        cyc();
        n_cmp++; if (key_out_a !== 16'h0) begin n_err++; $display("FAIL flight_key_zero: got %0h expected 0", key_out_a); end
    endtask

    task automatic test_terrain_mux();
        blank = 1'b1; draw_bomb_a = 2'b01;
        #1;
        n_cmp++; if (terrain_we_a !== 1'b0) begin n_err++; $display("FAIL we_own_bomb: got %0d expected 0", terrain_we_a); end
        draw_bomb_a = 2'b00; blank = 1'b0;
        #1;
        n_cmp++; if (terrain_we_a !== 1'b0) begin n_err++; $display("FAIL we_no_blank: got %0d expected 0", terrain_we_a); end
        blank = 1'b1;
        #1;
        n_cmp++; if (terrain_we_a !== 1'b1) begin n_err++; $display("FAIL we_flight: got %0d expected 1", terrain_we_a); end
        addr_player_a = {11'h155, 11'h0AA};
        addr_bomb_a   = {11'h3C3, 11'h07E};
        draw_player_a = 2'b10; draw_bomb_a = 2'b10;
        #1;
        n_cmp++; if (terrain_we_a !== 1'b1) begin n_err++; $display("FAIL we_other_bomb: got %0d expected 1", terrain_we_a); end
        n_cmp++; if (draw_player_o_a !== 1'b1) begin n_err++; $display("FAIL draw_player_or: got %0d expected 1", draw_player_o_a); end
        n_cmp++; if (addr_player_o_a !== 11'h155) begin n_err++; $display("FAIL addr_player_p1: got %0h expected 155", addr_player_o_a); end
        n_cmp++; if (addr_bomb_o_a !== 11'h3C3) begin n_err++; $display("FAIL addr_bomb_p1: got %0h expected 3c3", addr_bomb_o_a); end
        draw_player_a = 2'b11;
        #1;
        n_cmp++; if (addr_player_o_a !== 11'h0AA) begin n_err++; $display("FAIL addr_player_lowest: got %0h expected 0aa", addr_player_o_a); end
        draw_player_a = 2'b00; draw_bomb_a = 2'b00;
        #1;
        n_cmp++; if (draw_player_o_a !== 1'b0 || draw_bomb_o_a !== 1'b0) begin n_err++; $display("FAIL draw_or_idle: got %0d%0d expected 00", draw_player_o_a, draw_bomb_o_a); end
        n_cmp++; if (addr_player_o_a !== 11'h0 || addr_bomb_o_a !== 11'h0) begin n_err++; $display("FAIL addr_idle: got %0h/%0h expected 0/0", addr_player_o_a, addr_bomb_o_a); end
    endtask

    task automatic test_flight();
        bomb_done_a = 2'b10;
        cyc();
        bomb_done_a = 2'b00;
        repeat (30) tick();
        n_cmp++; if (active_id_a !== 1'b0) begin n_err++; $display("FAIL foreign_bomb_done: got %0d expected 0", active_id_a); end
        n_cmp++; if (terrain_we_a !== 1'b1) begin n_err++; $display("FAIL still_flight_we: got %0d expected 1", terrain_we_a); end
        bomb_done_a = 2'b01;
        cyc();
        bomb_done_a = 2'b00;
        repeat (29) tick();
        n_cmp++; if (active_id_a !== 1'b0) begin n_err++; $display("FAIL settle_29: got %0d expected 0", active_id_a); end
        tick();
        cyc();
        n_cmp++; if (active_id_a !== 1'b1) begin n_err++; $display("FAIL settle_done_active: got %0d expected 1", active_id_a); end
        n_cmp++; if (turn_left_a !== 10'd600) begin n_err++; $display("FAIL settle_done_turn_left: got %0d expected 600", turn_left_a); end
        keycode = 8'h04;
        cyc();
        n_cmp++; if (key_out_a !== 16'h0400) begin n_err++; $display("FAIL route_p1: got %0h expected 0400", key_out_a); end
        keycode = 8'h00;
    endtask

    task automatic test_timeout();
        alive_b = 4'b0011;
        do_reset();
        tick();
        n_cmp++; if (turn_left_b !== 3'd5) begin n_err++; $display("FAIL to_start: got %0d expected 5", turn_left_b); end
        repeat (4) tick();
        n_cmp++; if (turn_left_b !== 3'd1) begin n_err++; $display("FAIL to_count: got %0d expected 1", turn_left_b); end
        tick();
        cyc();
        n_cmp++; if (active_id_b !== 2'd1) begin n_err++; $display("FAIL to_forfeit: got %0d expected 1", active_id_b); end
        n_cmp++; if (turn_left_b !== 3'd5) begin n_err++; $display("FAIL to_reload: got %0d expected 5", turn_left_b); end
        repeat (4) tick();
        keycode = 8'h2C; frame_clk = 1'b1;
        cyc();
        keycode = 8'h00; frame_clk = 1'b0;
        cyc();
        n_cmp++; if (key_out_b !== 32'h0) begin n_err++; $display("FAIL fire5_key_zero: got %0h expected 0", key_out_b); end
        repeat (2) tick();
        n_cmp++; if (active_id_b !== 2'd1 || terrain_we_b !== 1'b1) begin n_err++; $display("FAIL fire5_flight: got id %0d we %0d expected id 1 we 1", active_id_b, terrain_we_b); end
    endtask

    task automatic test_fire_vs_timeout();
        bomb_done_b = 4'b0010;
        cyc();
        bomb_done_b = 4'b0000;
        repeat (3) tick();
        cyc();
        n_cmp++; if (active_id_b !== 2'd0) begin n_err++; $display("FAIL wrap_to_0: got %0d expected 0", active_id_b); end
        repeat (4) tick();
        frame_clk = 1'b1;
        cyc();
        n_cmp++; if (turn_left_b !== 3'd0) begin n_err++; $display("FAIL expired: got %0d expected 0", turn_left_b); end
        frame_clk = 1'b0; keycode = 8'h2C;
        cyc();
        n_cmp++; if (key_out_b !== 32'h2C) begin n_err++; $display("FAIL fire_at_zero_key: got %0h expected 2c", key_out_b); end
        keycode = 8'h00;
        cyc();
        n_cmp++; if (active_id_b !== 2'd0 || terrain_we_b !== 1'b1) begin n_err++; $display("FAIL fire_wins: got id %0d we %0d expected id 0 we 1", active_id_b, terrain_we_b); end
    endtask

    task automatic test_wrap();
        alive_b = 4'b1010;
        do_reset();
        tick();
        cyc();
        n_cmp++; if (active_id_b !== 2'd1) begin n_err++; $display("FAIL dead_skip: got %0d expected 1", active_id_b); end
        n_cmp++; if (turn_left_b !== 3'd5) begin n_err++; $display("FAIL dead_skip_reload: got %0d expected 5", turn_left_b); end
        repeat (5) tick();
        cyc();
        n_cmp++; if (active_id_b !== 2'd3) begin n_err++; $display("FAIL rr_1_to_3: got %0d expected 3", active_id_b); end
        repeat (5) tick();
        cyc();
        n_cmp++; if (active_id_b !== 2'd1) begin n_err++; $display("FAIL rr_3_to_1: got %0d expected 1", active_id_b); end
    endtask

    task automatic test_gameover();
        keycode = 8'h2C;
        cyc();
        keycode = 8'h00;
        cyc();
        bomb_done_b = 4'b0010;
        cyc();
        bomb_done_b = 4'b0000;
        alive_b = 4'b0100;
        repeat (3) tick();
        n_cmp++; if (game_over_b !== 1'b0) begin n_err++; $display("FAIL early_game_over: got %0d expected 0", game_over_b); end
        cyc();
        n_cmp++; if (game_over_b !== 1'b1) begin n_err++; $display("FAIL game_over: got %0d expected 1", game_over_b); end
        n_cmp++; if (winner_b !== 2'd2) begin n_err++; $display("FAIL winner: got %0d expected 2", winner_b); end
        keycode = 8'h04;
        tick();
        n_cmp++; if (key_out_b !== 32'h0 || game_over_b !== 1'b1 || terrain_we_b !== 1'b0) begin n_err++; $display("FAIL gameover_hold: got key %0h go %0d we %0d expected 0 1 0", key_out_b, game_over_b, terrain_we_b); end
        bomb_done_b = 4'b0100;
        reset = 1'b1;
        cyc();
        n_cmp++; if (game_over_b !== 1'b0 || winner_b !== 2'd0 || active_id_b !== 2'd0) begin n_err++; $display("FAIL reset_after_go: got go %0d win %0d id %0d expected 0 0 0", game_over_b, winner_b, active_id_b); end
        n_cmp++; if (turn_left_b !== 3'd5 || key_out_b !== 32'h0) begin n_err++; $display("FAIL reset_after_go_regs: got tl %0d key %0h expected 5 0", turn_left_b, key_out_b); end
        reset = 1'b0;
        cyc();
        bomb_done_b = 4'b0000;
        keycode = 8'h00;
        n_cmp++; if (terrain_we_b !== 1'b0) begin n_err++; $display("FAIL reset_drops_bomb: got %0d expected 0", terrain_we_b); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_turn_start();
        test_key_route();
        test_terrain_mux();
        test_flight();
        test_timeout();
        test_fire_vs_timeout();
        test_wrap();
        test_gameover();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
